// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard scheduler.
//   state_e      - sequencing FSM states (RUN, MD_WAIT)
//   REG_X0       - architectural index of the hard-wired zero register
//   pipe_ctrl_t  - the five pipeline-register enables and four flushes
//   ctrl_run()   - free-running pipeline: all enables high, no flushes
//   ctrl_reset() - every register disabled and loaded with a bubble
package hazard_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } state_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_flush;
      logic mem_wb_flush;
   } pipe_ctrl_t;

   function automatic pipe_ctrl_t ctrl_run();
      pipe_ctrl_t c;
      c.pc_en        = 1'b1;
      c.if_id_en     = 1'b1;
      c.id_ex_en     = 1'b1;
      c.ex_mem_en    = 1'b1;
      c.mem_wb_en    = 1'b1;
      c.if_id_flush  = 1'b0;
      c.id_ex_flush  = 1'b0;
      c.ex_mem_flush = 1'b0;
      c.mem_wb_flush = 1'b0;
      return c;
   endfunction

   function automatic pipe_ctrl_t ctrl_reset();
      pipe_ctrl_t c;
      c.pc_en        = 1'b0;
      c.if_id_en     = 1'b0;
      c.id_ex_en     = 1'b0;
      c.ex_mem_en    = 1'b0;
      c.mem_wb_en    = 1'b0;
      c.if_id_flush  = 1'b1;
      c.id_ex_flush  = 1'b1;
      c.ex_mem_flush = 1'b1;
      c.mem_wb_flush = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/hazard_scheduler_load_use_detect.sv
// load_use_detect: purely combinational load-use hazard comparator.
//   ID_rs1_i, ID_rs2_i         - source registers of the instruction in ID
//   ID_UsesRs1_i, ID_UsesRs2_i - the ID instruction really reads that source
//   EX_rd_i                    - destination of the instruction in EX
//   EX_MemRead_i               - the EX instruction is a load
//   load_use_o                 - ID needs the load result before it exists
module load_use_detect
   import hazard_pkg::*;
(
   input  logic [4:0] ID_rs1_i,
   input  logic [4:0] ID_rs2_i,
   input  logic       ID_UsesRs1_i,
   input  logic       ID_UsesRs2_i,
   input  logic [4:0] EX_rd_i,
   input  logic       EX_MemRead_i,
   output logic       load_use_o
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = ID_UsesRs1_i && (ID_rs1_i == EX_rd_i);
   assign rs2_hit = ID_UsesRs2_i && (ID_rs2_i == EX_rd_i);

   // A load into x0 writes nothing, so it can never feed a dependent read.
   assign load_use_o = EX_MemRead_i && (EX_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: pipeline sequencing controller for the 5-stage RV32 core.
// Owns every pipeline-register enable and flush and resolves, highest
// priority first: dmem wait states, mul/div occupancy, taken-branch flushes
// and load-use bubbles. Also counts stall and flush cycles.
//   clk, rst                         - clock, synchronous active-high reset
//   ID_rs1/rs2, ID_UsesRs1/Rs2       - ID-stage source operands
//   EX_rd, EX_MemRead                - EX-stage load destination
//   EX_BranchTaken, EX_MulDiv        - EX-stage control-flow / mul-div
//   md_done                          - mul/div result valid (held until used)
//   MEM_MemAccess, dmem_ready        - MEM-stage dmem access handshake
//   PC_En .. MEM_WB_En               - pipeline register write enables
//   IF_ID_Flush .. MEM_WB_Flush      - load a bubble into the register
//   md_start                         - one-cycle mul/div start pulse
//   md_error                         - sticky mul/div timeout flag
//   stall_cnt, flush_cnt             - wrapping performance counters
module hazard_scheduler
   import hazard_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ID_rs1,
   input  logic [4:0]       ID_rs2,
   input  logic             ID_UsesRs1,
   input  logic             ID_UsesRs2,
   input  logic [4:0]       EX_rd,
   input  logic             EX_MemRead,
   input  logic             EX_BranchTaken,
   input  logic             EX_MulDiv,
   input  logic             md_done,
   input  logic             MEM_MemAccess,
   input  logic             dmem_ready,
   output logic             PC_En,
   output logic             IF_ID_En,
   output logic             ID_EX_En,
   output logic             EX_MEM_En,
   output logic             MEM_WB_En,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             EX_MEM_Flush,
   output logic             MEM_WB_Flush,
   output logic             md_start,
   output logic             md_error,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int              TMR_W    = $clog2(MD_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             md_err_q, md_err_d;
   logic             md_skip_q, md_skip_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   pipe_ctrl_t       ctrl;
   logic             md_start_c;
   logic             branch_flush;
   logic             mem_stall;
   logic             load_use;

   load_use_detect u_load_use (
      .ID_rs1_i     (ID_rs1),
      .ID_rs2_i     (ID_rs2),
      .ID_UsesRs1_i (ID_UsesRs1),
      .ID_UsesRs2_i (ID_UsesRs2),
      .EX_rd_i      (EX_rd),
      .EX_MemRead_i (EX_MemRead),
      .load_use_o   (load_use)
   );

   assign mem_stall = MEM_MemAccess && !dmem_ready;

   always_comb begin
      ctrl         = ctrl_run();
      md_start_c   = 1'b0;
      branch_flush = 1'b0;
      state_d      = state_q;
      timer_d      = timer_q;
      md_err_d     = md_err_q;
      md_skip_d    = 1'b0;

      if (rst) begin
         ctrl     = ctrl_reset();
         state_d  = RUN;
         timer_d  = '0;
         md_err_d = 1'b0;
      end else if (mem_stall) begin
         // Everything upstream of MEM/WB freezes; a held md_done is not
         // consumed because EX/MEM cannot capture the result.
         ctrl.pc_en        = 1'b0;
         ctrl.if_id_en     = 1'b0;
         ctrl.id_ex_en     = 1'b0;
         ctrl.ex_mem_en    = 1'b0;
         ctrl.mem_wb_flush = 1'b1;
         md_skip_d         = md_skip_q;
         // Saturate so the timeout still fires once the stall clears.
         if (state_q == MD_WAIT && timer_q != TMR_LAST) begin
            timer_d = timer_q + 1'b1;
         end
      end else if (state_q == MD_WAIT) begin
         if (md_done) begin
            state_d = RUN;
            timer_d = '0;
         end else begin
            ctrl.pc_en        = 1'b0;
            ctrl.if_id_en     = 1'b0;
            ctrl.id_ex_en     = 1'b0;
            ctrl.ex_mem_flush = 1'b1;
            if (timer_q == TMR_LAST) begin
               // Abort: drop the stuck op and the instruction behind it.
               // ID/EX stays disabled, so the mul/div flag may still be
               // visible next cycle; suppress a second start for it.
               ctrl.id_ex_flush = 1'b1;
               md_err_d         = 1'b1;
               state_d          = RUN;
               timer_d          = '0;
               md_skip_d        = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
      end else if (EX_MulDiv && !md_skip_q) begin
         ctrl.pc_en        = 1'b0;
         ctrl.if_id_en     = 1'b0;
         ctrl.id_ex_en     = 1'b0;
         ctrl.ex_mem_flush = 1'b1;
         md_start_c        = 1'b1;
         state_d           = MD_WAIT;
         timer_d           = '0;
      end else if (EX_BranchTaken) begin
         ctrl.if_id_flush = 1'b1;
         ctrl.id_ex_flush = 1'b1;
         branch_flush     = 1'b1;
      end else if (load_use) begin
         ctrl.pc_en       = 1'b0;
         ctrl.if_id_en    = 1'b0;
         ctrl.id_ex_flush = 1'b1;
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!rst && !ctrl.pc_en) begin
         stall_d = stall_q + CNT_W'(1);
      end
      if (branch_flush) begin
         flush_d = flush_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RUN;
         timer_q   <= '0;
         md_err_q  <= 1'b0;
         md_skip_q <= 1'b0;
         stall_q   <= '0;
         flush_q   <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         md_err_q  <= md_err_d;
         md_skip_q <= md_skip_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   assign PC_En        = ctrl.pc_en;
   assign IF_ID_En     = ctrl.if_id_en;
   assign ID_EX_En     = ctrl.id_ex_en;
   assign EX_MEM_En    = ctrl.ex_mem_en;
   assign MEM_WB_En    = ctrl.mem_wb_en;
   assign IF_ID_Flush  = ctrl.if_id_flush;
   assign ID_EX_Flush  = ctrl.id_ex_flush;
   assign EX_MEM_Flush = ctrl.ex_mem_flush;
   assign MEM_WB_Flush = ctrl.mem_wb_flush;
   assign md_start     = md_start_c;
   assign md_error     = md_err_q;
   assign stall_cnt    = stall_q;
   assign flush_cnt    = flush_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
module tb_hazard_scheduler;

   localparam int MD_TO = 8;
   localparam int CW    = 32;

   // Packed control view: {PC,IF_ID,ID_EX,EX_MEM,MEM_WB enables,
   //                       IF_ID,ID_EX,EX_MEM,MEM_WB flushes, md_start}
   localparam logic [9:0] C_RUN = 10'b11111_0000_0;
   localparam logic [9:0] C_RST = 10'b00000_1111_0;
   localparam logic [9:0] C_LU  = 10'b00111_0100_0;
   localparam logic [9:0] C_BR  = 10'b11111_1100_0;
   localparam logic [9:0] C_MDS = 10'b00011_0010_1;
   localparam logic [9:0] C_MDW = 10'b00011_0010_0;
   localparam logic [9:0] C_TO  = 10'b00011_0110_0;
   localparam logic [9:0] C_MEM = 10'b00001_0001_0;

   typedef struct {
      logic [9:0]    ctrl;
      logic          err;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
      string         name;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    ID_rs1, ID_rs2, EX_rd;
   logic          ID_UsesRs1, ID_UsesRs2, EX_MemRead, EX_BranchTaken, EX_MulDiv;
   logic          md_done, MEM_MemAccess, dmem_ready;
   logic          PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En;
   logic          IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush;
   logic          md_start, md_error;
   logic [CW-1:0] stall_cnt, flush_cnt;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   hazard_scheduler #(.MD_TIMEOUT(MD_TO), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .ID_rs1         (ID_rs1),
      .ID_rs2         (ID_rs2),
      .ID_UsesRs1     (ID_UsesRs1),
      .ID_UsesRs2     (ID_UsesRs2),
      .EX_rd          (EX_rd),
      .EX_MemRead     (EX_MemRead),
      .EX_BranchTaken (EX_BranchTaken),
      .EX_MulDiv      (EX_MulDiv),
      .md_done        (md_done),
      .MEM_MemAccess  (MEM_MemAccess),
      .dmem_ready     (dmem_ready),
      .PC_En          (PC_En),
      .IF_ID_En       (IF_ID_En),
      .ID_EX_En       (ID_EX_En),
      .EX_MEM_En      (EX_MEM_En),
      .MEM_WB_En      (MEM_WB_En),
      .IF_ID_Flush    (IF_ID_Flush),
      .ID_EX_Flush    (ID_EX_Flush),
      .EX_MEM_Flush   (EX_MEM_Flush),
      .MEM_WB_Flush   (MEM_WB_Flush),
      .md_start       (md_start),
      .md_error       (md_error),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   // Monitor: the DUT presents a full control word every cycle; compare at
   // the falling edge against the oldest queued expectation.
   initial begin
      exp_t       e;
      logic [9:0] got;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {PC_En, IF_ID_En, ID_EX_En, EX_MEM_En, MEM_WB_En,
                   IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush, md_start};
            total++;
            if (got !== e.ctrl) begin
               bad++;
               $display("FAIL %s ctrl: got %b want %b", e.name, got, e.ctrl);
            end
            total++;
            if (md_error !== e.err) begin
               bad++;
               $display("FAIL %s md_error: got %b want %b", e.name, md_error, e.err);
            end
            total++;
            if (stall_cnt !== e.stall) begin
               bad++;
               $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.stall);
            end
            total++;
            if (flush_cnt !== e.flush) begin
               bad++;
               $display("FAIL %s flush_cnt: got %0d want %0d", e.name, flush_cnt, e.flush);
            end
         end
      end
   end

   task automatic clr();
      rst            = 1'b0;
      ID_rs1         = 5'd0;
      ID_rs2         = 5'd0;
      ID_UsesRs1     = 1'b0;
      ID_UsesRs2     = 1'b0;
      EX_rd          = 5'd0;
      EX_MemRead     = 1'b0;
      EX_BranchTaken = 1'b0;
      EX_MulDiv      = 1'b0;
      md_done        = 1'b0;
      MEM_MemAccess  = 1'b0;
      dmem_ready     = 1'b1;
   endtask

   // Queue the expected outputs for the inputs currently applied, then
   // advance one clock.
   task automatic v(input logic [9:0] c, input logic e, input int s, input int f,
                    input string n);
      exp_t x;
      x.ctrl  = c;
      x.err   = e;
      x.stall = CW'(s);
      x.flush = CW'(f);
      x.name  = n;
      exp_q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      rst = 1'b1;
      @(posedge clk);
      #1;
      v(C_RST, 0, 0, 0, "reset_a");
      v(C_RST, 0, 0, 0, "reset_b");
      clr();
      v(C_RUN, 0, 0, 0, "idle");

      // Load-use on rs1, one bubble, then x0 and rs2 variants
      EX_MemRead = 1; EX_rd = 5'd6; ID_rs1 = 5'd6; ID_UsesRs1 = 1;
      v(C_LU, 0, 0, 0, "lu_rs1");
      clr();
      v(C_RUN, 0, 1, 0, "lu_after");
      EX_MemRead = 1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_UsesRs1 = 1;
      v(C_RUN, 0, 1, 0, "lu_x0");
      clr();
      EX_MemRead = 1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_UsesRs2 = 1; ID_rs1 = 5'd5;
      v(C_LU, 0, 1, 0, "lu_rs2");
      clr();
      EX_MemRead = 1; EX_rd = 5'd7; ID_rs1 = 5'd7; ID_UsesRs1 = 0;
      v(C_RUN, 0, 2, 0, "lu_unused");

      // Branch wins over a simultaneous load-use
      clr();
      EX_MemRead = 1; EX_rd = 5'd6; ID_rs1 = 5'd6; ID_UsesRs1 = 1; EX_BranchTaken = 1;
      v(C_BR, 0, 2, 0, "br_lu");
      clr();
      v(C_RUN, 0, 2, 1, "br_after");

      // Mul/div: start, five waits, release
      EX_MulDiv = 1;
      v(C_MDS, 0, 2, 1, "md_start");
      for (int i = 0; i < 5; i++) v(C_MDW, 0, 3 + i, 1, "md_wait");
      md_done = 1;
      v(C_RUN, 0, 8, 1, "md_release");
      clr();
      v(C_RUN, 0, 8, 1, "md_after");

      // dmem wait for three cycles
      MEM_MemAccess = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) v(C_MEM, 0, 8 + i, 1, "mem_wait");
      dmem_ready = 1;
      v(C_RUN, 0, 11, 1, "mem_done");

      // md_done held across a dmem wait
      clr();
      EX_MulDiv = 1;
      v(C_MDS, 0, 11, 1, "md2_start");
      v(C_MDW, 0, 12, 1, "md2_wait");
      md_done = 1; MEM_MemAccess = 1; dmem_ready = 0;
      v(C_MEM, 0, 13, 1, "md2_memstall_a");
      v(C_MEM, 0, 14, 1, "md2_memstall_b");
      dmem_ready = 1;
      v(C_RUN, 0, 15, 1, "md2_release");
      clr();
      v(C_RUN, 0, 15, 1, "md2_after");

      // Timeout, then the held mul/div flag must not restart
      EX_MulDiv = 1;
      v(C_MDS, 0, 15, 1, "to_start");
      for (int i = 0; i < MD_TO - 1; i++) v(C_MDW, 0, 16 + i, 1, "to_wait");
      v(C_TO, 0, 23, 1, "to_abort");
      v(C_RUN, 1, 24, 1, "to_no_restart");
      clr();
      v(C_RUN, 1, 24, 1, "to_after");

      // Reset in the middle of MD_WAIT
      EX_MulDiv = 1;
      v(C_MDS, 1, 24, 1, "rst_md_start");
      v(C_MDW, 1, 25, 1, "rst_md_wait");
      rst = 1;
      v(C_RST, 1, 26, 1, "rst_mid");
      clr();
      v(C_RUN, 0, 0, 0, "rst_run_a");
      v(C_RUN, 0, 0, 0, "rst_run_b");

      for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
